regfile_param: RTL and testbench
================================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL have parameter XLEN, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of entries (power of 2, at least 4); AW = log2(DEPTH).
REQ-003 SHALL have parameter NREAD, default 2, number of independent read ports (1..4).
REQ-004 SHALL have parameter BYPASS, default 1: 1 = write-to-read forwarding in the same cycle, 0 = no forwarding.
REQ-005 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port RADDR  input  NREAD*AW  read addresses; port k uses bits [k*AW +: AW].
REQ-008 SHALL have port RDATA  output  NREAD*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
REQ-009 SHALL have port WRITEENABLE  input  1  write request.
REQ-010 SHALL have port WRITEADDRESS  input  AW  write target entry.
REQ-011 SHALL have port WRITEDATA  input  XLEN  write value.
REQ-012 SHALL have port CLEAR  input  1  bulk-clear request, sampled on a rising edge.
REQ-013 SHALL have port BUSY  output  1  high while the bulk clear is in progress.
REQ-014 SHALL have port DROPPED  output  1  one-cycle pulse flagging a write rejected on the previous edge.

Function
REQ-015 SHALL hardwire entry 0 to zero: every read of address 0 returns 0, and writes to address 0 are discarded without asserting DROPPED.
REQ-016 SHALL accept a write on a rising edge when WRITEENABLE=1, BUSY=0 and WRITEADDRESS!=0; the entry updates on that edge.
REQ-017 SHALL make reads combinational, zero latency: RDATA[k] = entry[RADDR[k]], independently per port.
REQ-018 SHALL, when BYPASS=1 and a write is being accepted in the current cycle (REQ-016 conditions true), return WRITEDATA on every read port whose RADDR equals that nonzero WRITEADDRESS.
REQ-019 SHALL, when BYPASS=0, return the pre-edge stored value in the case of REQ-018.
REQ-020 SHALL implement a two-state clear FSM with states IDLE and CLR.
REQ-021 SHALL transition IDLE->CLR on a rising edge with CLEAR=1, and load the clear counter with 1.
REQ-022 SHALL, in CLR, zero entry[counter] on each rising edge and then increment the counter; the edge that zeroes entry DEPTH-1 returns the FSM to IDLE.
REQ-023 SHALL drive BUSY=1 exactly while in CLR, giving DEPTH-1 cycles per clear (31 for the defaults).
REQ-024 SHALL ignore CLEAR while in CLR; clearing does not restart or extend.
REQ-025 SHALL reject a write with WRITEENABLE=1, BUSY=1 and WRITEADDRESS!=0: storage is unchanged, there is no bypass, and DROPPED=1 for the following cycle.
REQ-026 SHALL accept a write in the same edge that samples CLEAR=1 in IDLE; the following clear sweep then zeroes that entry.
REQ-027 SHALL return current stored contents on reads during CLR: already-swept entries read 0 and unswept entries keep their old values.
REQ-028 SHALL make DROPPED a registered output, high for exactly one cycle for each rejected write.

Reset
REQ-029 SHALL, with RESET=0 and independent of CLK, zero all entries, force the FSM to IDLE, zero the counter, and drive BUSY=0 and DROPPED=0.
REQ-030 SHALL abort any in-progress clear on a reset asserted mid-CLR; after release the block is in IDLE with all entries 0.
REQ-031 SHALL resume normal operation on the first rising edge after RESET returns high.

Verification
REQ-032 SHALL cover: reset, then write 0xA5A5A5A5 to entry 1 and 0x5A5A5A5A to entry 2; next cycle RADDR={2,1} -> RDATA={0x5A5A5A5A,0xA5A5A5A5}.
REQ-033 SHALL cover: write 0xDEADBEEF to entry 0, then read address 0 on all ports -> 0, DROPPED=0.
REQ-034 SHALL cover: BYPASS=1, write 0x12345678 to entry 5 while RADDR port0=5 -> RDATA0=0x12345678 in the same cycle; with BYPASS=0 -> the old value.
REQ-035 SHALL cover: fill entries 1..31, pulse CLEAR -> BUSY high for 31 cycles; a write to entry 7 mid-clear -> DROPPED pulse, and all entries read 0 afterward.
REQ-036 SHALL cover: CLEAR and a write to entry 3 (0x11) on the same edge -> write accepted, entry 3 reads 0x11 until swept, then 0.
REQ-037 SHALL cover: assert RESET low at cycle 10 of a clear -> BUSY=0 immediately, all entries 0, and CLEAR works normally after release.

Source files
------------

// File: rtl/regfile_param.sv
// Parameterised multi-read-port register file with hardwired-zero entry 0,
// optional write-to-read forwarding and a background bulk-clear sweep.
module regfile_param #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [NREAD*AW-1:0]   RADDR,
    output logic [NREAD*XLEN-1:0] RDATA,
    input  logic                  WRITEENABLE,
    input  logic [AW-1:0]         WRITEADDRESS,
    input  logic [XLEN-1:0]       WRITEDATA,
    input  logic                  CLEAR,
    output logic                  BUSY,
    output logic                  DROPPED
);

    localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

    typedef enum logic {StIdle, StClr} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] mem_q [DEPTH];
    logic            dropped_q;

    logic            busy;
    logic            wr_accept;
    logic            wr_reject;

    assign busy      = (state_q == StClr);
    assign wr_accept = WRITEENABLE && !busy && (WRITEADDRESS != '0);
    assign wr_reject = WRITEENABLE && busy && (WRITEADDRESS != '0);

    assign BUSY    = busy;
    assign DROPPED = dropped_q;

    // Clear FSM next state: IDLE starts a sweep at entry 1, CLR walks to the last entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (CLEAR) begin
                    state_d = StClr;
                    cnt_d   = AW'(1);
                end
            end
            StClr: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == LastIdx) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // Clear FSM state, sweep counter and the rejected-write flag.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dropped_q <= wr_reject;
        end
    end

    // Storage: sweep zeroing while clearing, otherwise accepted writes.
    // Writes are never accepted during a sweep, so the two never collide.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (busy) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_accept) begin
            mem_q[WRITEADDRESS] <= WRITEDATA;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_read
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;

        assign ra = RADDR[k*AW +: AW];
        assign RDATA[k*XLEN +: XLEN] = rd;

        // Combinational read; entry 0 reads zero, forwarding only for accepted writes.
        always_comb begin
            if (ra == '0) begin
                rd = '0;
            end else if ((BYPASS != 0) && wr_accept && (ra == WRITEADDRESS)) begin
                rd = WRITEDATA;
            end else begin
                rd = mem_q[ra];
            end
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: a bypassing and a non-bypassing
// instance share stimulus; a cycle model feeds expected values to a scoreboard.
module tb_regfile_param;

    localparam int XLEN  = 32;
    localparam int DEPTH = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic                  CLK = 1'b0;
    logic                  RESET = 1'b1;
    logic [NREAD*AW-1:0]   RADDR = '0;
    logic                  WRITEENABLE = 1'b0;
    logic [AW-1:0]         WRITEADDRESS = '0;
    logic [XLEN-1:0]       WRITEDATA = '0;
    logic                  CLEAR = 1'b0;
    logic [NREAD*XLEN-1:0] rdata_byp, rdata_nob;
    logic                  busy_byp, busy_nob, drop_byp, drop_nob;

    regfile_param #(.XLEN(XLEN), .DEPTH(DEPTH), .NREAD(NREAD), .BYPASS(1)) u_byp (
        .CLK          (CLK),
        .RESET        (RESET),
        .RADDR        (RADDR),
        .RDATA        (rdata_byp),
        .WRITEENABLE  (WRITEENABLE),
        .WRITEADDRESS (WRITEADDRESS),
        .WRITEDATA    (WRITEDATA),
        .CLEAR        (CLEAR),
        .BUSY         (busy_byp),
        .DROPPED      (drop_byp)
    );

    regfile_param #(.XLEN(XLEN), .DEPTH(DEPTH), .NREAD(NREAD), .BYPASS(0)) u_nob (
        .CLK          (CLK),
        .RESET        (RESET),
        .RADDR        (RADDR),
        .RDATA        (rdata_nob),
        .WRITEENABLE  (WRITEENABLE),
        .WRITEADDRESS (WRITEADDRESS),
        .WRITEDATA    (WRITEDATA),
        .CLEAR        (CLEAR),
        .BUSY         (busy_nob),
        .DROPPED      (drop_nob)
    );

    always #5 CLK = ~CLK;

    // Reference model state
    logic [31:0] m [DEPTH];
    logic        m_busy;
    logic        m_drop;
    logic [4:0]  m_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_busy_seen;
    int          n_drop_seen;
    string       tag_q [$];
    logic [31:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] e);
        tag_q.push_back(tag);
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        string       t;
        logic [31:0] e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        check_eq(t, got, e);
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] a, input bit byp, input bit acc,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'h0;
        if (byp && acc && a == wa) return wd;
        return m[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m[i] = 32'h0;
        m_busy = 1'b0;
        m_drop = 1'b0;
        m_cnt  = 5'd0;
    endtask

    // One clock cycle: drive, push expectations, compare at negedge, advance model.
    task automatic cycle(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                         input bit clr, input logic [4:0] ra0, input logic [4:0] ra1);
        bit acc;
        WRITEENABLE  = we;
        WRITEADDRESS = wa;
        WRITEDATA    = wd;
        CLEAR        = clr;
        RADDR        = {ra1, ra0};
        acc = we && !m_busy && (wa != 5'd0);
        sb_push($sformatf("rd0_byp@%0d", ra0), model_rd(ra0, 1'b1, acc, wa, wd));
        sb_push($sformatf("rd1_byp@%0d", ra1), model_rd(ra1, 1'b1, acc, wa, wd));
        sb_push($sformatf("rd0_nob@%0d", ra0), model_rd(ra0, 1'b0, acc, wa, wd));
        sb_push($sformatf("rd1_nob@%0d", ra1), model_rd(ra1, 1'b0, acc, wa, wd));
        sb_push("busy_byp", 32'(m_busy));
        sb_push("dropped_byp", 32'(m_drop));
        sb_push("busy_nob", 32'(m_busy));
        sb_push("dropped_nob", 32'(m_drop));
        @(negedge CLK);
        sb_pop(rdata_byp[31:0]);
        sb_pop(rdata_byp[63:32]);
        sb_pop(rdata_nob[31:0]);
        sb_pop(rdata_nob[63:32]);
        sb_pop(32'(busy_byp));
        sb_pop(32'(drop_byp));
        sb_pop(32'(busy_nob));
        sb_pop(32'(drop_nob));
        if (busy_byp) n_busy_seen++;
        if (drop_byp) n_drop_seen++;
        @(posedge CLK);
        m_drop = we && m_busy && (wa != 5'd0);
        if (m_busy) begin
            m[m_cnt] = 32'h0;
            if (m_cnt == 5'd31) m_busy = 1'b0;
            m_cnt = m_cnt + 5'd1;
        end else if (clr) begin
            m_busy = 1'b1;
            m_cnt  = 5'd1;
        end
        if (acc) m[wa] = wd;
        #1;
        WRITEENABLE = 1'b0;
        CLEAR       = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();

        // Asynchronous reset with no clock edge yet
        #1 RESET = 1'b0;
        #2;
        RADDR = {5'd31, 5'd5};
        #1;
        check_eq("rst_busy", 32'(busy_byp), 32'h0);
        check_eq("rst_dropped", 32'(drop_byp), 32'h0);
        check_eq("rst_rd0", rdata_byp[31:0], 32'h0);
        check_eq("rst_rd1", rdata_byp[63:32], 32'h0);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;

        // Basic writes then read {2,1}
        cycle(1'b1, 5'd1, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd0);
        cycle(1'b1, 5'd2, 32'h5A5A5A5A, 1'b0, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 5'd2);

        // Write to entry 0 is discarded silently
        cycle(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);

        // Same-cycle forwarding vs. old value
        cycle(1'b1, 5'd5, 32'h0BAD0005, 1'b0, 5'd0, 5'd0);
        cycle(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd5, 5'd5);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd1);
        cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd5);

        // Fill, bulk clear, rejected write and ignored CLEAR mid-sweep
        for (int i = 1; i < DEPTH; i++) begin
            cycle(1'b1, 5'(i), 32'hC0DE0000 | 32'(i), 1'b0, 5'(i), 5'(i - 1));
        end
        n_busy_seen = 0;
        n_drop_seen = 0;
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd20);
        for (int j = 0; j < 40; j++) begin
            if (j == 5) cycle(1'b1, 5'd7, 32'hFFFF0007, 1'b0, 5'd7, 5'd30);
            else if (j == 8) cycle(1'b1, 5'd0, 32'hFFFF0000, 1'b0, 5'd0, 5'd31);
            else if (j == 10) cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'(j), 5'(31 - j));
            else cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'(j), 5'(31 - j));
        end
        check_eq("busy_cycles", 32'(n_busy_seen), 32'd31);
        check_eq("drop_pulses", 32'(n_drop_seen), 32'd1);
        for (int a = 0; a < 16; a++) begin
            cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'(2 * a), 5'(2 * a + 1));
        end

        // CLEAR and write on the same edge
        cycle(1'b1, 5'd9, 32'h00000099, 1'b0, 5'd0, 5'd0);
        cycle(1'b1, 5'd3, 32'h00000011, 1'b1, 5'd3, 5'd9);
        for (int j = 0; j < 36; j++) begin
            cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd9);
        end

        // Reset asserted mid-clear
        for (int i = 1; i < DEPTH; i++) begin
            cycle(1'b1, 5'(i), 32'h00A00000 + 32'(i * 3), 1'b0, 5'd0, 5'd0);
        end
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
        for (int j = 0; j < 9; j++) begin
            cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd20, 5'd2);
        end
        RESET = 1'b0;
        #1;
        check_eq("midclr_rst_busy_byp", 32'(busy_byp), 32'h0);
        check_eq("midclr_rst_busy_nob", 32'(busy_nob), 32'h0);
        check_eq("midclr_rst_dropped", 32'(drop_byp), 32'h0);
        model_reset();
        for (int a = 24; a < DEPTH; a++) begin
            RADDR = {5'(a), 5'(a - 20)};
            #0.5;
            check_eq($sformatf("midclr_rst_rd0@%0d", a - 20), rdata_byp[31:0], 32'h0);
            check_eq($sformatf("midclr_rst_rd1@%0d", a), rdata_nob[63:32], 32'h0);
        end
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd20, 5'd31);
        cycle(1'b1, 5'd4, 32'h00000044, 1'b0, 5'd4, 5'd0);
        n_busy_seen = 0;
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd0);
        for (int j = 0; j < 36; j++) begin
            cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 5'(j));
        end
        check_eq("busy_cycles_after_rst", 32'(n_busy_seen), 32'd31);

        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
